// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXE/MEM/WB sequencer for the 16-bit RISC core.
// Define MULTICYCLE_CTRL_WATCHDOG_EN to halt with bus_err after WAIT_MAX stalled memory cycles.
module multicycle_ctrl #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter int          WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        mem_rdy,
  input  logic [15:0] mem_rdata,
  input  logic        C,
  input  logic        Z,
  input  logic        N,
  output logic [15:0] PC,
  output logic [10:0] Ins,
  output logic        IF_req,
  output logic        MEM_req,
  output logic        MEM_we,
  output logic        WBRF,
  output logic        WBresource,
  output logic        RBresource,
  output logic        OprandB,
  output logic        LI,
  output logic        Buff_OutR,
  output logic        ALUop,
  output logic        Flag,
  output logic        PSW_C,
  output logic        PSW_Z,
  output logic        PSW_N,
  output logic        halted,
  output logic        bus_err
);
  typedef enum logic [2:0] {FETCH, DECODE, EXE, MEM, WB, HALT} state_t;
  localparam logic [4:0] OP_ADC  = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_SBB  = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_SUBI = 5'd6;
  localparam logic [4:0] OP_LHI  = 5'd8;
  localparam logic [4:0] OP_LD   = 5'd9;
  localparam logic [4:0] OP_ST   = 5'd10;
  localparam logic [4:0] OP_OUT  = 5'd11;
  localparam logic [4:0] OP_HLT  = 5'd31;
  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d, ir_q, ir_d;
  logic [2:0]  psw_q, psw_d;
  logic [11:0] ctl_q, ctl_d;
  logic [4:0]  op, op_d;
  logic        arith, exe_op, mem_op;
  assign op     = ir_q[15:11];
  assign op_d   = ir_d[15:11];
  assign arith  = op inside {[5'd1:5'd6]};
  assign exe_op = op inside {[5'd1:5'd10]};
  assign mem_op = op inside {OP_LD, OP_ST};
`ifdef MULTICYCLE_CTRL_WATCHDOG_EN
  localparam logic [3:0] WLIM = 4'(WAIT_MAX - 1);
  logic [3:0] wcnt_q, wcnt_d;
  logic       bus_err_q, bus_err_d;
  assign bus_err = bus_err_q;
`else
  logic unused_wait_max;
  assign unused_wait_max = ^WAIT_MAX;
  assign bus_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    psw_d   = psw_q;
    case (state_q)
      FETCH: if (mem_rdy) begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + 16'd1;
        state_d = DECODE;
      end
      DECODE: state_d = op == OP_HLT ? HALT : exe_op ? EXE : FETCH;
      EXE: begin
        psw_d   = arith ? {C, Z, N} : psw_q;
        state_d = mem_op ? MEM : WB;
      end
      MEM:     if (mem_rdy) state_d = op == OP_LD ? WB : FETCH;
      WB:      state_d = FETCH;
      default: state_d = HALT;
    endcase
`ifdef MULTICYCLE_CTRL_WATCHDOG_EN
    wcnt_d    = 4'd0;
    bus_err_d = bus_err_q;
    if ((state_q == FETCH || state_q == MEM) && !mem_rdy) begin
      if (wcnt_q == WLIM) begin
        state_d   = HALT;
        bus_err_d = 1'b1;
      end else wcnt_d = wcnt_q + 4'd1;
    end
`endif
    // strobes are decoded one cycle early so they leave the block registered
    ctl_d = {state_d == FETCH,
             state_d == MEM,
             state_d == MEM && op_d == OP_ST,
             state_d == WB,
             state_d == WB && op_d == OP_LD,
             state_d == DECODE && op_d inside {OP_ST, OP_LHI},
             state_d == DECODE && op_d inside {OP_ADDI, OP_SUBI, OP_LD, OP_ST},
             state_d == DECODE && op_d == OP_LHI,
             state_d == DECODE && op_d == OP_OUT,
             state_d == EXE && op_d inside {OP_SUB, OP_SBB, OP_SUBI},
             state_d == EXE && op_d inside {OP_ADC, OP_SBB},
             state_d == HALT};
  end
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= FETCH;
      pc_q    <= PC_RESET;
      ir_q    <= '0;
      psw_q   <= '0;
      ctl_q   <= 12'h800;
`ifdef MULTICYCLE_CTRL_WATCHDOG_EN
      wcnt_q    <= '0;
      bus_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      psw_q   <= psw_d;
      ctl_q   <= ctl_d;
`ifdef MULTICYCLE_CTRL_WATCHDOG_EN
      wcnt_q    <= wcnt_d;
      bus_err_q <= bus_err_d;
`endif
    end
  end
  assign {IF_req, MEM_req, MEM_we, WBRF, WBresource, RBresource,
          OprandB, LI, Buff_OutR, ALUop, Flag, halted} = ctl_q;
  assign PC  = pc_q;
  assign Ins = ir_q[10:0];
  assign {PSW_C, PSW_Z, PSW_N} = psw_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: instruction-level scoreboard bench for multicycle_ctrl.
module tb_multicycle_ctrl;
  logic        clk = 1'b0, Reset = 1'b1, mem_rdy = 1'b0, C = 1'b0, Z = 1'b0, N = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] PC, w_PC;
  logic [10:0] Ins, w_Ins;
  logic IF_req, MEM_req, MEM_we, WBRF, WBresource, RBresource, OprandB, LI, Buff_OutR, ALUop, Flag;
  logic PSW_C, PSW_Z, PSW_N, halted, bus_err;
  logic w_IF_req, w_MEM_req, w_MEM_we, w_WBRF, w_WBresource, w_RBresource, w_OprandB, w_LI;
  logic w_Buff_OutR, w_ALUop, w_Flag, w_PSW_C, w_PSW_Z, w_PSW_N, w_halted, w_bus_err;

  multicycle_ctrl u_dut (
    .clk(clk), .Reset(Reset), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .C(C), .Z(Z), .N(N),
    .PC(PC), .Ins(Ins), .IF_req(IF_req), .MEM_req(MEM_req), .MEM_we(MEM_we), .WBRF(WBRF),
    .WBresource(WBresource), .RBresource(RBresource), .OprandB(OprandB), .LI(LI),
    .Buff_OutR(Buff_OutR), .ALUop(ALUop), .Flag(Flag), .PSW_C(PSW_C), .PSW_Z(PSW_Z),
    .PSW_N(PSW_N), .halted(halted), .bus_err(bus_err));

  multicycle_ctrl #(.PC_RESET(16'hFFFF)) u_wrap (
    .clk(clk), .Reset(Reset), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .C(C), .Z(Z), .N(N),
    .PC(w_PC), .Ins(w_Ins), .IF_req(w_IF_req), .MEM_req(w_MEM_req), .MEM_we(w_MEM_we),
    .WBRF(w_WBRF), .WBresource(w_WBresource), .RBresource(w_RBresource), .OprandB(w_OprandB),
    .LI(w_LI), .Buff_OutR(w_Buff_OutR), .ALUop(w_ALUop), .Flag(w_Flag), .PSW_C(w_PSW_C),
    .PSW_Z(w_PSW_Z), .PSW_N(w_PSW_N), .halted(w_halted), .bus_err(w_bus_err));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [2:0]  psw;
    int          cyc;
    int          wb;
    logic        wbres;
    int          wbat;
    int          mreq;
    int          mwe;
    int          aluop;
    int          flag;
    logic [3:0]  dec;
    logic [10:0] ins;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0, errors = 0;
  logic [15:0] m_pc = '0;
  logic [2:0]  m_psw = '0;
  logic        watch_wb = 1'b0;
  int          wb_pulses = 0;

  always @(negedge clk) if (watch_wb && WBRF === 1'b1) wb_pulses++;

  task automatic step;
    @(negedge clk);
  endtask

  // one instruction: expected behaviour is queued at fetch, observed behaviour is popped and compared
  task automatic exec(input logic [15:0] ins, input int fwait, input int mwait, input logic [2:0] czn);
    exp_t e, g;
    logic [4:0] op;
    int n, mc;
    op = ins[15:11];
    e = '{default: 0};
    e.cyc   = (op inside {[5'd1:5'd10]}) ? (op == 5'd9 ? 5 + mwait : op == 5'd10 ? 4 + mwait : 4) : 2;
    e.wb    = (op inside {[5'd1:5'd9]}) ? 1 : 0;
    e.wbres = op == 5'd9;
    e.wbat  = e.wb == 1 ? e.cyc : 0;
    e.mreq  = (op == 5'd9 || op == 5'd10) ? mwait + 1 : 0;
    e.mwe   = op == 5'd10 ? mwait + 1 : 0;
    e.aluop = (op == 5'd3 || op == 5'd4 || op == 5'd6) ? 1 : 0;
    e.flag  = (op == 5'd2 || op == 5'd4) ? 1 : 0;
    e.dec   = {op == 5'd10 || op == 5'd8, op inside {5'd5, 5'd6, 5'd9, 5'd10}, op == 5'd8, op == 5'd11};
    m_pc = m_pc + 16'd1;
    if (op inside {[5'd1:5'd6]}) m_psw = czn;
    e.pc  = m_pc;
    e.psw = m_psw;
    e.ins = ins[10:0];
    sb.push_back(e);
    {C, Z, N} = czn;
    n = 0;
    while (IF_req !== 1'b1 && n < 20) begin step; n++; end
    vectors++;
    if (IF_req !== 1'b1) begin errors++; $display("FAIL fetch_wait: IF_req=%b want 1", IF_req); end
    repeat (fwait) step;
    mem_rdy = 1'b1;
    mem_rdata = ins;
    step;
    mem_rdy = 1'b0;
    g = '{default: 0};
    g.cyc = 1;
    mc = 0;
    while (IF_req !== 1'b1 && halted !== 1'b1 && g.cyc < 40) begin
      g.cyc++;
      if (g.cyc == 2) g.dec = {RBresource, OprandB, LI, Buff_OutR};
      if (WBRF === 1'b1) begin g.wb++; g.wbres = WBresource; g.wbat = g.cyc; end
      g.mreq  += int'(MEM_req);
      g.mwe   += int'(MEM_we);
      g.aluop += int'(ALUop);
      g.flag  += int'(Flag);
      mem_rdata = 16'($urandom);
      mem_rdy = MEM_req ? (mc >= mwait) : 1'($urandom_range(0, 1));
      mc += int'(MEM_req);
      step;
      mem_rdy = 1'b0;
    end
    g.pc  = PC;
    g.psw = {PSW_C, PSW_Z, PSW_N};
    g.ins = Ins;
    e = sb.pop_front();
    vectors += 12;
    if (g.pc !== e.pc) begin errors++; $display("FAIL pc(%h): got %h want %h", ins, g.pc, e.pc); end
    if (g.psw !== e.psw) begin errors++; $display("FAIL psw(%h): got %b want %b", ins, g.psw, e.psw); end
    if (g.cyc != e.cyc) begin errors++; $display("FAIL cycles(%h): got %0d want %0d", ins, g.cyc, e.cyc); end
    if (g.wb != e.wb) begin errors++; $display("FAIL wbrf_count(%h): got %0d want %0d", ins, g.wb, e.wb); end
    if (g.wbres !== e.wbres) begin errors++; $display("FAIL wbresource(%h): got %b want %b", ins, g.wbres, e.wbres); end
    if (g.wbat != e.wbat) begin errors++; $display("FAIL wbrf_cycle(%h): got %0d want %0d", ins, g.wbat, e.wbat); end
    if (g.mreq != e.mreq) begin errors++; $display("FAIL mem_req(%h): got %0d want %0d", ins, g.mreq, e.mreq); end
    if (g.mwe != e.mwe) begin errors++; $display("FAIL mem_we(%h): got %0d want %0d", ins, g.mwe, e.mwe); end
    if (g.aluop != e.aluop) begin errors++; $display("FAIL aluop(%h): got %0d want %0d", ins, g.aluop, e.aluop); end
    if (g.flag != e.flag) begin errors++; $display("FAIL flag(%h): got %0d want %0d", ins, g.flag, e.flag); end
    if (g.dec !== e.dec) begin errors++; $display("FAIL decode_strobes(%h): got %b want %b", ins, g.dec, e.dec); end
    if (g.ins !== e.ins) begin errors++; $display("FAIL ins(%h): got %h want %h", ins, g.ins, e.ins); end
  endtask

  task automatic test_reset;
    #1 Reset = 1'b0;
    step;
    step;
    vectors += 6;
    if (PC !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want 0000", PC); end
    if (IF_req !== 1'b1) begin errors++; $display("FAIL reset_if_req: got %b want 1", IF_req); end
    if ({MEM_req, MEM_we, WBRF, WBresource, RBresource, OprandB, LI, Buff_OutR, ALUop, Flag} !== 10'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 0", {MEM_req, MEM_we, WBRF, WBresource, RBresource, OprandB, LI, Buff_OutR, ALUop, Flag});
    end
    if ({PSW_C, PSW_Z, PSW_N, Ins} !== 14'b0) begin errors++; $display("FAIL reset_psw_ins: got %b/%h want 000/000", {PSW_C, PSW_Z, PSW_N}, Ins); end
    if ({halted, bus_err} !== 2'b00) begin errors++; $display("FAIL reset_halt_err: got %b want 00", {halted, bus_err}); end
    if (w_PC !== 16'hFFFF) begin errors++; $display("FAIL reset_pc_param: got %h want ffff", w_PC); end
    Reset = 1'b1;
    m_pc = 16'h0000;
    m_psw = 3'b000;
  endtask

  task automatic test_add;
    exec({5'd1, 11'h0A5}, 0, 0, 3'b001);
    exec({5'd1, 11'h312}, 3, 0, 3'b100);
  endtask

  task automatic test_sub_lli;
    exec({5'd3, 11'h14C}, 0, 0, 3'b110);
    exec({5'd7, 11'h2FF}, 0, 0, 3'b001);
  endtask

  task automatic test_decode;
    exec({5'd2, 11'h011}, 2, 0, 3'b011);
    exec({5'd4, 11'h222}, 0, 0, 3'b101);
    exec({5'd5, 11'h01F}, 0, 0, 3'b010);
    exec({5'd6, 11'h3E1}, 1, 0, 3'b111);
    exec({5'd8, 11'h4AB}, 0, 0, 3'b000);
    exec({5'd11, 11'h100}, 0, 0, 3'b000);
    exec(16'h0000, 0, 0, 3'b001);
    exec({5'd12, 11'h7FF}, 0, 0, 3'b100);
    exec({5'd20, 11'h055}, 0, 0, 3'b010);
  endtask

  task automatic test_mem;
    exec({5'd9, 11'h123}, 0, 3, 3'b000);
    exec({5'd10, 11'h456}, 0, 0, 3'b111);
    exec({5'd10, 11'h0F0}, 0, 2, 3'b000);
    exec({5'd9, 11'h701}, 1, 0, 3'b101);
  endtask

  task automatic test_reset_mid;
    int n;
    wb_pulses = 0;
    watch_wb = 1'b1;
    {C, Z, N} = 3'b111;
    n = 0;
    while (IF_req !== 1'b1 && n < 20) begin step; n++; end
    mem_rdy = 1'b1;
    mem_rdata = {5'd1, 11'h0A5};
    step;
    mem_rdy = 1'b0;
    step;
    #2 Reset = 1'b0;
    #1;
    vectors += 4;
    if (PC !== 16'h0000) begin errors++; $display("FAIL abort_pc: got %h want 0000", PC); end
    if ({PSW_C, PSW_Z, PSW_N} !== 3'b000) begin errors++; $display("FAIL abort_psw: got %b want 000", {PSW_C, PSW_Z, PSW_N}); end
    if (IF_req !== 1'b1) begin errors++; $display("FAIL abort_if_req: got %b want 1", IF_req); end
    if (Ins !== 11'h000) begin errors++; $display("FAIL abort_ins: got %h want 000", Ins); end
    repeat (3) step;
    Reset = 1'b1;
    step;
    vectors += 2;
    if ({IF_req, PC} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL release_fetch: got %b/%h want 1/0000", IF_req, PC); end
    watch_wb = 1'b0;
    if (wb_pulses != 0) begin errors++; $display("FAIL abort_wbrf: got %0d pulses want 0", wb_pulses); end
    m_pc = 16'h0000;
    m_psw = 3'b000;
    exec({5'd1, 11'h0A5}, 0, 0, 3'b010);
  endtask

  task automatic test_wrap_halt;
    int bad;
    Reset = 1'b0;
    step;
    Reset = 1'b1;
    m_pc = 16'h0000;
    m_psw = 3'b000;
    vectors++;
    if (w_PC !== 16'hFFFF) begin errors++; $display("FAIL wrap_start: got %h want ffff", w_PC); end
    exec(16'h0000, 0, 0, 3'b000);
    vectors++;
    if ({w_IF_req, w_PC} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL pc_wrap: got %b/%h want 1/0000", w_IF_req, w_PC); end
    exec(16'hF800, 0, 0, 3'b000);
    vectors++;
    if ({halted, w_halted} !== 2'b11) begin errors++; $display("FAIL halt_entry: got %b want 11", {halted, w_halted}); end
    bad = 0;
    repeat (20) begin
      mem_rdy = 1'($urandom_range(0, 1));
      step;
      if ({IF_req, MEM_req, WBRF, halted, w_IF_req, w_halted} !== 6'b000101) bad++;
    end
    mem_rdy = 1'b0;
    vectors++;
    if (bad != 0) begin errors++; $display("FAIL halt_hold: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_watchdog;
    Reset = 1'b0;
    step;
    Reset = 1'b1;
    mem_rdy = 1'b0;
    repeat (14) step;
    vectors++;
    if ({IF_req, halted, bus_err} !== 3'b100) begin errors++; $display("FAIL wait_14: got %b want 100", {IF_req, halted, bus_err}); end
    step;
    vectors++;
`ifdef MULTICYCLE_CTRL_WATCHDOG_EN
    if ({IF_req, halted, bus_err} !== 3'b011) begin errors++; $display("FAIL watchdog_trip: got %b want 011", {IF_req, halted, bus_err}); end
`else
    if ({IF_req, halted, bus_err} !== 3'b100) begin errors++; $display("FAIL wait_15: got %b want 100", {IF_req, halted, bus_err}); end
    repeat (30) step;
    vectors++;
    if ({IF_req, halted, bus_err} !== 3'b100) begin errors++; $display("FAIL wait_45: got %b want 100", {IF_req, halted, bus_err}); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_add;
    test_sub_lli;
    test_decode;
    test_mem;
    test_reset_mid;
    test_wrap_halt;
    test_watchdog;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
